// File: rtl/glcd_panel_responder_pkg.sv
// Shared constants for the GLCD panel responder: panel geometry, instruction
// opcode masks/values, status-byte bit positions and small helpers.
package glcd_panel_responder_pkg;

    // Panel geometry: two controller chips, each 8 pages x 64 columns.
    localparam int NUM_CHIPS = 2;
    localparam int NUM_PAGES = 8;
    localparam int NUM_COLS  = 64;
    localparam int PAGE_W    = 3;
    localparam int COL_W     = 6;
    localparam int ADDR_W    = 1 + PAGE_W + COL_W;

    // Instruction opcodes as (mask, value) pairs.
    localparam logic [7:0] OP_ON_MASK         = 8'hFF;
    localparam logic [7:0] OP_ON_VAL          = 8'h3F;
    localparam logic [7:0] OP_OFF_MASK        = 8'hFF;
    localparam logic [7:0] OP_OFF_VAL         = 8'h3E;
    localparam logic [7:0] OP_SET_Y_MASK      = 8'hC0;
    localparam logic [7:0] OP_SET_Y_VAL       = 8'h40;
    localparam logic [7:0] OP_SET_PAGE_MASK   = 8'hF8;
    localparam logic [7:0] OP_SET_PAGE_VAL    = 8'hB8;
    localparam logic [7:0] OP_START_LINE_MASK = 8'hC0;
    localparam logic [7:0] OP_START_LINE_VAL  = 8'hC0;

    // Status byte bit positions (all other bits read as zero).
    localparam int ST_BUSY_BIT  = 7;
    localparam int ST_OFF_BIT   = 5;
    localparam int ST_RESET_BIT = 4;

    typedef enum logic [2:0] {
        INS_NONE,
        INS_ON,
        INS_OFF,
        INS_SET_Y,
        INS_SET_PAGE,
        INS_START_LINE
    } instr_e;

    // Classify an instruction byte; unknown codes map to INS_NONE.
    function automatic instr_e decode_instr(input logic [7:0] code);
        instr_e res;
        res = INS_NONE;
        if ((code & OP_ON_MASK) == OP_ON_VAL)
            res = INS_ON;
        else if ((code & OP_OFF_MASK) == OP_OFF_VAL)
            res = INS_OFF;
        else if ((code & OP_SET_Y_MASK) == OP_SET_Y_VAL)
            res = INS_SET_Y;
        else if ((code & OP_SET_PAGE_MASK) == OP_SET_PAGE_VAL)
            res = INS_SET_PAGE;
        else if ((code & OP_START_LINE_MASK) == OP_START_LINE_VAL)
            res = INS_START_LINE;
        return res;
    endfunction

    // Flat display-RAM address: {chip, page, column}.
    function automatic logic [ADDR_W-1:0] ram_addr(input logic chip,
                                                   input logic [PAGE_W-1:0] page,
                                                   input logic [COL_W-1:0] col);
        return {chip, page, col};
    endfunction

endpackage

// File: rtl/glcd_dpram.sv
// Display RAM for both chips: 1024 x 8, one write port and two registered
// read ports (bus-side read and inspection read). Reads return the old data
// when the same address is written in the same cycle.
module glcd_dpram
    import glcd_panel_responder_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [7:0]        rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [7:0]        rdata_b
);

    localparam int DEPTH = NUM_CHIPS * NUM_PAGES * NUM_COLS;

    logic [7:0] mem [DEPTH];

    // Write port; the array itself is never reset so it maps onto block RAM.
    always_ff @(posedge CLK) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Registered read ports; the output registers clear on RESET.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rdata_a <= 8'h00;
            rdata_b <= 8'h00;
        end else begin
            rdata_a <= mem[raddr_a];
            rdata_b <= mem[raddr_b];
        end
    end

endmodule

// File: rtl/glcd_panel_responder.sv
// Behavioural responder for a two-chip graphic LCD panel: synchronizes the
// host's E strobe and panel reset, executes one bus transaction per falling
// edge of synchronized E, and keeps per-chip display state plus display RAM.
module glcd_panel_responder
    import glcd_panel_responder_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       LCD_ENABLE,
    input  logic       LCD_RW,
    input  logic       LCD_DI,
    input  logic       LCD_CS1,
    input  logic       LCD_CS2,
    input  logic       LCD_RST,
    input  logic [7:0] LCD_DATA_IN,
    output logic [7:0] LCD_DATA_OUT,
    output logic       LCD_DATA_OE,
    input  logic       RD_CHIP,
    input  logic [2:0] RD_PAGE,
    input  logic [5:0] RD_COL,
    output logic [7:0] RD_DATA,
    output logic [1:0] DISP_ON,
    output logic [5:0] START_LINE0,
    output logic [5:0] START_LINE1,
    output logic       WR_STROBE
);

    logic e_meta_reg, e_sync_reg, e_dly_reg;
    logic rst_meta_reg, rst_sync_reg;

    logic       cap_rw_reg, cap_di_reg, cap_cs1_reg, cap_cs2_reg;
    logic [7:0] cap_data_reg;

    logic              wr_en_reg, wr_pend_reg, wr_strobe_reg;
    logic [ADDR_W-1:0] wr_addr_reg, wr_pend_addr_reg;
    logic [7:0]        wr_data_reg;
    logic              latch_load_reg, latch_chip_reg;

    logic                              e_fall, exec, cap_chip;
    logic                              instr_wr, data_wr, data_rd;
    logic [NUM_CHIPS-1:0]              chip_sel;
    instr_e                            instr;
    logic [NUM_CHIPS-1:0][COL_W-1:0]   y_cur;
    logic [NUM_CHIPS-1:0][PAGE_W-1:0]  page_cur;
    logic [NUM_CHIPS-1:0]              on_cur;
    logic [NUM_CHIPS-1:0][5:0]         start_cur;
    logic [NUM_CHIPS-1:0][7:0]         latch_cur;
    logic [ADDR_W-1:0]                 bus_rd_addr;
    logic [7:0]                        bus_rd_data;
    logic                              out_chip;
    logic [7:0]                        status_byte;

    // Two-flop synchronizers for E and panel reset, plus one E history flop.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            e_meta_reg   <= 1'b0;
            e_sync_reg   <= 1'b0;
            e_dly_reg    <= 1'b0;
            rst_meta_reg <= 1'b0;
            rst_sync_reg <= 1'b0;
        end else begin
            e_meta_reg   <= LCD_ENABLE;
            e_sync_reg   <= e_meta_reg;
            e_dly_reg    <= e_sync_reg;
            rst_meta_reg <= LCD_RST;
            rst_sync_reg <= rst_meta_reg;
        end
    end

    // Track the bus controls every cycle while synchronized E is high.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cap_rw_reg   <= 1'b0;
            cap_di_reg   <= 1'b0;
            cap_cs1_reg  <= 1'b0;
            cap_cs2_reg  <= 1'b0;
            cap_data_reg <= 8'h00;
        end else if (e_sync_reg) begin
            cap_rw_reg   <= LCD_RW;
            cap_di_reg   <= LCD_DI;
            cap_cs1_reg  <= LCD_CS1;
            cap_cs2_reg  <= LCD_CS2;
            cap_data_reg <= LCD_DATA_IN;
        end
    end

    // A falling edge while the panel is held in reset is simply dropped.
    assign e_fall   = e_dly_reg & ~e_sync_reg;
    assign exec     = e_fall & rst_sync_reg & (cap_cs1_reg | cap_cs2_reg);
    assign cap_chip = ~cap_cs1_reg;
    assign instr_wr = exec & ~cap_rw_reg & ~cap_di_reg;
    assign data_wr  = exec & ~cap_rw_reg &  cap_di_reg;
    assign data_rd  = exec &  cap_rw_reg &  cap_di_reg;
    assign instr    = decode_instr(cap_data_reg);

    // Writes go to every selected chip; reads with both selects go to chip 0.
    assign chip_sel[0] = cap_cs1_reg;
    assign chip_sel[1] = cap_cs2_reg & (~cap_rw_reg | ~cap_cs1_reg);

    for (genvar gi = 0; gi < NUM_CHIPS; gi++) begin : g_chip
        logic [COL_W-1:0]  y_reg;
        logic [PAGE_W-1:0] page_reg;
        logic              on_reg;
        logic [5:0]        start_reg;
        logic [7:0]        latch_reg;

        // Per-chip display state: panel reset forces defaults, else apply the transaction.
        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                y_reg     <= '0;
                page_reg  <= '0;
                on_reg    <= 1'b0;
                start_reg <= '0;
            end else if (!rst_sync_reg) begin
                y_reg     <= '0;
                page_reg  <= '0;
                on_reg    <= 1'b0;
                start_reg <= '0;
            end else if (chip_sel[gi]) begin
                if (instr_wr) begin
                    case (instr)
                        INS_ON:         on_reg    <= 1'b1;
                        INS_OFF:        on_reg    <= 1'b0;
                        INS_SET_Y:      y_reg     <= cap_data_reg[COL_W-1:0];
                        INS_SET_PAGE:   page_reg  <= cap_data_reg[PAGE_W-1:0];
                        INS_START_LINE: start_reg <= cap_data_reg[5:0];
                        default:        ;
                    endcase
                end
                if (data_wr || data_rd)
                    y_reg <= y_reg + 1'b1;
            end
        end

        // Output latch loads the RAM byte one cycle after a data read executes.
        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET)
                latch_reg <= 8'h00;
            else if (latch_load_reg && (latch_chip_reg == 1'(gi)))
                latch_reg <= bus_rd_data;
        end

        assign y_cur[gi]     = y_reg;
        assign page_cur[gi]  = page_reg;
        assign on_cur[gi]    = on_reg;
        assign start_cur[gi] = start_reg;
        assign latch_cur[gi] = latch_reg;
    end

    // Bus-side read address follows the captured chip's cursor, so the RAM
    // output already holds the addressed byte when the read executes.
    assign bus_rd_addr = ram_addr(cap_chip, page_cur[cap_chip], y_cur[cap_chip]);

    // Registered write port; a two-chip data write is split over two cycles.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_en_reg        <= 1'b0;
            wr_pend_reg      <= 1'b0;
            wr_addr_reg      <= '0;
            wr_pend_addr_reg <= '0;
            wr_data_reg      <= 8'h00;
            wr_strobe_reg    <= 1'b0;
            latch_load_reg   <= 1'b0;
            latch_chip_reg   <= 1'b0;
        end else begin
            wr_strobe_reg  <= data_wr;
            latch_load_reg <= data_rd;
            latch_chip_reg <= cap_chip;
            if (data_wr) begin
                wr_en_reg        <= 1'b1;
                wr_data_reg      <= cap_data_reg;
                wr_addr_reg      <= cap_cs1_reg ? ram_addr(1'b0, page_cur[0], y_cur[0])
                                                : ram_addr(1'b1, page_cur[1], y_cur[1]);
                wr_pend_reg      <= cap_cs1_reg & cap_cs2_reg;
                wr_pend_addr_reg <= ram_addr(1'b1, page_cur[1], y_cur[1]);
            end else if (wr_pend_reg) begin
                wr_en_reg   <= 1'b1;
                wr_addr_reg <= wr_pend_addr_reg;
                wr_pend_reg <= 1'b0;
            end else begin
                wr_en_reg <= 1'b0;
            end
        end
    end

    glcd_dpram u_ram (
        .CLK     (CLK),
        .RESET   (RESET),
        .we      (wr_en_reg),
        .waddr   (wr_addr_reg),
        .wdata   (wr_data_reg),
        .raddr_a (bus_rd_addr),
        .rdata_a (bus_rd_data),
        .raddr_b (ram_addr(RD_CHIP, RD_PAGE, RD_COL)),
        .rdata_b (RD_DATA)
    );

    // Panel drives the bus while synchronized E is high on a selected read.
    always_comb begin
        out_chip    = ~LCD_CS1;
        LCD_DATA_OE = e_sync_reg & LCD_RW & (LCD_CS1 | LCD_CS2);
        status_byte = 8'h00;
        status_byte[ST_BUSY_BIT]  = 1'b0;
        status_byte[ST_OFF_BIT]   = ~on_cur[out_chip];
        status_byte[ST_RESET_BIT] = ~rst_sync_reg;
        LCD_DATA_OUT = 8'h00;
        if (LCD_DATA_OE)
            LCD_DATA_OUT = LCD_DI ? latch_cur[out_chip] : status_byte;
    end

    assign DISP_ON     = on_cur;
    assign START_LINE0 = start_cur[0];
    assign START_LINE1 = start_cur[1];
    assign WR_STROBE   = wr_strobe_reg;

endmodule

// File: tb/tb_glcd_panel_responder.sv
// Scoreboard bench for glcd_panel_responder: directed sequences followed by
// randomized bus traffic, checked against a behavioural panel model.
module tb_glcd_panel_responder;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       LCD_ENABLE = 1'b0;
    logic       LCD_RW = 1'b0;
    logic       LCD_DI = 1'b0;
    logic       LCD_CS1 = 1'b0;
    logic       LCD_CS2 = 1'b0;
    logic       LCD_RST = 1'b1;
    logic [7:0] LCD_DATA_IN = 8'h00;
    logic       RD_CHIP = 1'b0;
    logic [2:0] RD_PAGE = 3'd0;
    logic [5:0] RD_COL = 6'd0;
    logic [7:0] LCD_DATA_OUT;
    logic       LCD_DATA_OE;
    logic [7:0] RD_DATA;
    logic [1:0] DISP_ON;
    logic [5:0] START_LINE0;
    logic [5:0] START_LINE1;
    logic       WR_STROBE;

    glcd_panel_responder dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .LCD_ENABLE   (LCD_ENABLE),
        .LCD_RW       (LCD_RW),
        .LCD_DI       (LCD_DI),
        .LCD_CS1      (LCD_CS1),
        .LCD_CS2      (LCD_CS2),
        .LCD_RST      (LCD_RST),
        .LCD_DATA_IN  (LCD_DATA_IN),
        .LCD_DATA_OUT (LCD_DATA_OUT),
        .LCD_DATA_OE  (LCD_DATA_OE),
        .RD_CHIP      (RD_CHIP),
        .RD_PAGE      (RD_PAGE),
        .RD_COL       (RD_COL),
        .RD_DATA      (RD_DATA),
        .DISP_ON      (DISP_ON),
        .START_LINE0  (START_LINE0),
        .START_LINE1  (START_LINE1),
        .WR_STROBE    (WR_STROBE)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the panel.
    logic [7:0] mem_m [2][8][64];
    int         y_m [2];
    int         pg_m [2];
    int         sl_m [2];
    bit         on_m [2];
    logic [7:0] lat_m [2];
    bit         prst_low = 1'b0;
    int         strobes_m = 0;

    // Scoreboard queues and monitor state.
    logic [7:0] rdq [$];
    logic [7:0] inspq [$];
    int         strobe_cnt = 0;
    logic       oe_prev = 1'b0;
    logic       insp_tag = 1'b0;
    logic       insp_d = 1'b0;
    logic [7:0] exp_mon;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset_state();
        for (int k = 0; k < 2; k++) begin
            y_m[k]  = 0;
            pg_m[k] = 0;
            sl_m[k] = 0;
            on_m[k] = 1'b0;
        end
    endtask

    // Apply one bus transaction to the model; reads queue their expected byte.
    task automatic model_xfer(input logic rw, input logic di, input logic cs1,
                              input logic cs2, input logic [7:0] d);
        int c;
        logic [7:0] st;
        c = cs1 ? 0 : 1;
        if (rw && (cs1 || cs2)) begin
            if (di) begin
                rdq.push_back(lat_m[c]);
            end else begin
                st = 8'h00;
                if (!on_m[c]) st = st + 8'h20;
                if (prst_low) st = st + 8'h10;
                rdq.push_back(st);
            end
        end
        if (prst_low || !(cs1 || cs2)) return;
        for (int k = 0; k < 2; k++) begin
            if ((k == 0 && cs1) || (k == 1 && cs2)) begin
                if (!rw && !di) begin
                    if (d == 8'h3F) on_m[k] = 1'b1;
                    else if (d == 8'h3E) on_m[k] = 1'b0;
                    else if (d >= 8'h40 && d < 8'h80) y_m[k] = int'(d) - 64;
                    else if (d >= 8'hB8 && d < 8'hC0) pg_m[k] = int'(d) - 184;
                    else if (d >= 8'hC0) sl_m[k] = int'(d) - 192;
                end else if (!rw && di) begin
                    mem_m[k][pg_m[k]][y_m[k]] = d;
                    y_m[k] = (y_m[k] + 1) % 64;
                end
            end
        end
        if (!rw && di) strobes_m++;
        if (rw && di) begin
            lat_m[c] = mem_m[c][pg_m[c]][y_m[c]];
            y_m[c] = (y_m[c] + 1) % 64;
        end
    endtask

    // One complete E-strobe transaction with settle time afterwards.
    task automatic bus(input logic rw, input logic di, input logic cs1,
                       input logic cs2, input logic [7:0] d);
        @(posedge CLK); #1;
        LCD_RW = rw; LCD_DI = di; LCD_CS1 = cs1; LCD_CS2 = cs2; LCD_DATA_IN = d;
        model_xfer(rw, di, cs1, cs2, d);
        $display("txn rw=%0d di=%0d cs=%0d%0d data=%02h", rw, di, cs1, cs2, d);
        LCD_ENABLE = 1'b1;
        repeat (4) @(posedge CLK);
        #1 LCD_ENABLE = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        if (rw && (cs1 || cs2)) begin
            chk("rd_consumed", rdq.size(), 0);
            chk("oe_low_after_e", LCD_DATA_OE, 1'b0);
        end
        if (!rw && di) chk("strobe_cnt", strobe_cnt, strobes_m);
    endtask

    task automatic instr(input logic cs1, input logic cs2, input logic [7:0] code);
        bus(1'b0, 1'b0, cs1, cs2, code);
    endtask

    // Inspection-port read: expected byte is queued, monitor compares next cycle.
    task automatic insp(input int c, input int p, input int col);
        @(posedge CLK); #1;
        RD_CHIP = c[0]; RD_PAGE = p[2:0]; RD_COL = col[5:0];
        inspq.push_back(mem_m[c][p][col]);
        insp_tag = 1'b1;
        @(posedge CLK); #1;
        insp_tag = 1'b0;
        @(negedge CLK);
        #1 chk("insp_consumed", inspq.size(), 0);
    endtask

    task automatic rand_cs(output logic a, output logic b);
        int r;
        r = $urandom_range(0, 7);
        a = (r == 1 || r == 2 || r >= 5);
        b = (r == 3 || r == 4 || r >= 5);
    endtask

    always @(posedge CLK) insp_d <= insp_tag;

    // Monitor: bus reads on OE rise, inspection reads, and strobe counting.
    always @(negedge CLK) begin
        if (WR_STROBE === 1'b1) strobe_cnt++;
        if (LCD_DATA_OE === 1'b1 && oe_prev !== 1'b1) begin
            checks++;
            if (rdq.size() == 0) begin
                errors++;
                $display("FAIL bus_read unexpected drive actual=%02h required=none", LCD_DATA_OUT);
            end else begin
                exp_mon = rdq.pop_front();
                if (LCD_DATA_OUT !== exp_mon) begin
                    errors++;
                    $display("FAIL bus_read actual=%02h required=%02h", LCD_DATA_OUT, exp_mon);
                end
            end
        end
        oe_prev = LCD_DATA_OE;
        if (insp_d) begin
            checks++;
            if (inspq.size() == 0) begin
                errors++;
                $display("FAIL rd_data no expectation actual=%02h", RD_DATA);
            end else begin
                exp_mon = inspq.pop_front();
                if (RD_DATA !== exp_mon) begin
                    errors++;
                    $display("FAIL rd_data chip=%0d page=%0d col=%0d actual=%02h required=%02h",
                             RD_CHIP, RD_PAGE, RD_COL, RD_DATA, exp_mon);
                end
            end
        end
    end

    initial begin
        logic a, b;
        int op;
        int base;

        model_reset_state();
        lat_m[0] = 8'h00;
        lat_m[1] = 8'h00;

        // Reset state.
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_disp_on", DISP_ON, 2'b00);
        chk("rst_start0", START_LINE0, 6'd0);
        chk("rst_start1", START_LINE1, 6'd0);
        chk("rst_oe", LCD_DATA_OE, 1'b0);
        chk("rst_data_out", LCD_DATA_OUT, 8'h00);
        chk("rst_wr_strobe", WR_STROBE, 1'b0);
        chk("rst_rd_data", RD_DATA, 8'h00);
        RESET = 1'b1;
        repeat (4) @(posedge CLK);

        // Initialisation sequence on both chips.
        instr(1, 1, 8'h3F);
        instr(1, 1, 8'hC5);
        instr(1, 1, 8'h40);
        instr(1, 1, 8'hBE);
        chk("init_disp_on", DISP_ON, 2'b11);
        chk("init_start0", START_LINE0, 6'd5);
        chk("init_start1", START_LINE1, 6'd5);
        bus(0, 1, 1, 1, 8'h99);
        insp(0, 6, 0);
        insp(1, 6, 0);

        // Fill all of display RAM so later reads hit defined bytes.
        for (int p = 0; p < 8; p++) begin
            instr(1, 1, 8'hB8 + 8'(p));
            instr(1, 1, 8'h40);
            for (int col = 0; col < 64; col++)
                bus(0, 1, 1, 1, 8'($urandom));
        end

        // Chip 0 page 6 full-row write with Y wrap.
        instr(1, 0, 8'hBE);
        instr(1, 0, 8'h40);
        base = strobe_cnt;
        for (int n = 0; n < 64; n++) bus(0, 1, 1, 0, 8'(n));
        chk("row_strobes", strobe_cnt - base, 64);
        for (int n = 0; n < 64; n++) insp(0, 6, n);
        for (int n = 0; n < 8; n++) insp(1, 6, n * 9);
        bus(1, 1, 1, 0, 8'h00);
        bus(1, 1, 1, 0, 8'h00);

        // Y = 63 boundary.
        instr(1, 0, 8'h7F);
        bus(0, 1, 1, 0, 8'hAA);
        bus(0, 1, 1, 0, 8'h55);
        insp(0, 6, 63);
        insp(0, 6, 0);

        // Dummy-read latch behaviour.
        instr(1, 0, 8'h42);
        bus(0, 1, 1, 0, 8'h11);
        bus(0, 1, 1, 0, 8'h22);
        instr(1, 0, 8'h42);
        bus(1, 1, 1, 0, 8'h00);
        bus(1, 1, 1, 0, 8'h00);
        bus(1, 1, 1, 0, 8'h00);

        // Status reads, display off, then with panel reset held.
        instr(1, 1, 8'h3E);
        bus(1, 0, 1, 0, 8'h00);
        bus(1, 0, 0, 1, 8'h00);
        LCD_RST = 1'b0;
        prst_low = 1'b1;
        model_reset_state();
        repeat (4) @(posedge CLK);
        bus(1, 0, 1, 0, 8'h00);
        bus(0, 1, 1, 1, 8'hEE);
        instr(1, 1, 8'h3F);
        chk("prst_disp_on", DISP_ON, 2'b00);
        chk("prst_start0", START_LINE0, 6'd0);
        insp(0, 0, 0);
        insp(1, 0, 0);
        LCD_RST = 1'b1;
        prst_low = 1'b0;
        repeat (4) @(posedge CLK);

        // Randomized traffic.
        for (int it = 0; it < 250; it++) begin
            op = $urandom_range(0, 9);
            rand_cs(a, b);
            case (op)
                0: instr(a, b, 8'hB8 + 8'($urandom_range(0, 7)));
                1: instr(a, b, 8'h40 + 8'($urandom_range(0, 63)));
                2, 3, 4: bus(0, 1, a, b, 8'($urandom));
                5, 6: bus(1, 1, a, b, 8'h00);
                7: bus(1, 0, a, b, 8'h00);
                8: instr(a, b, ($urandom_range(0, 1) == 1) ? 8'h3F : 8'h3E);
                default: instr(a, b, 8'($urandom_range(0, 255)));
            endcase
            if (it % 3 == 0)
                insp($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 63));
        end
        chk("rand_disp_on", DISP_ON, {on_m[1], on_m[0]});
        chk("rand_start0", START_LINE0, sl_m[0]);
        chk("rand_start1", START_LINE1, sl_m[1]);

        // RESET asserted in the middle of a data write to chip 0 RAM[0][0].
        instr(1, 0, 8'h3F);
        instr(1, 0, 8'hB8);
        instr(1, 0, 8'h40);
        bus(0, 1, 1, 0, 8'h5A);
        instr(1, 0, 8'h40);
        base = strobe_cnt;
        @(posedge CLK); #1;
        LCD_RW = 1'b0; LCD_DI = 1'b1; LCD_CS1 = 1'b1; LCD_CS2 = 1'b0; LCD_DATA_IN = 8'h77;
        $display("txn rw=0 di=1 cs=10 data=77 reset-abort");
        LCD_ENABLE = 1'b1;
        repeat (3) @(posedge CLK);
        #2 RESET = 1'b0;
        #3 LCD_ENABLE = 1'b0;
        @(posedge CLK); #1;
        chk("abort_disp_on", DISP_ON, 2'b00);
        chk("abort_start0", START_LINE0, 6'd0);
        chk("abort_start1", START_LINE1, 6'd0);
        chk("abort_oe", LCD_DATA_OE, 1'b0);
        chk("abort_data_out", LCD_DATA_OUT, 8'h00);
        chk("abort_wr_strobe", WR_STROBE, 1'b0);
        chk("abort_rd_data", RD_DATA, 8'h00);
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b1;
        model_reset_state();
        lat_m[0] = 8'h00;
        lat_m[1] = 8'h00;
        repeat (6) @(posedge CLK);
        #1 chk("abort_strobes", strobe_cnt - base, 0);
        insp(0, 0, 0);
        bus(1, 0, 1, 0, 8'h00);
        bus(1, 1, 1, 0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/glcd_panel_responder.md
GLCD_PANEL_RESPONDER -- requirements
Module: glcd_panel_responder

Interface
REQ-001 CLK  input  1  system clock; all internal state on rising edge.
REQ-002 RESET  input  1  asynchronous, active-low; clock CLK.
REQ-003 LCD_ENABLE  input  1  panel E strobe from driver, asynchronous to CLK; high pulse >= 3 CLK periods.
REQ-004 LCD_RW  input  1  1 = read, 0 = write.
REQ-005 LCD_DI  input  1  1 = data, 0 = instruction/status.
REQ-006 LCD_CS1 / LCD_CS2  input  1 each  active-high chip selects: left half (chip 0) / right half (chip 1).
REQ-007 LCD_RST  input  1  active-low panel reset.
REQ-008 LCD_DATA_IN  input  8  bus value driven by host.
REQ-009 LCD_DATA_OUT  output  8  bus value driven by panel on reads.
REQ-010 LCD_DATA_OE  output  1  high while panel drives the bus.
REQ-011 RD_CHIP / RD_PAGE / RD_COL  input  1 / 3 / 6  display-RAM inspection address.
REQ-012 RD_DATA  output  8  display-RAM byte at inspection address.
REQ-013 DISP_ON  output  2  per-chip display-on flag.
REQ-014 START_LINE0 / START_LINE1  output  6 each  per-chip start line.
REQ-015 WR_STROBE  output  1  one-cycle pulse per committed data write.

Function
REQ-016 LCD_ENABLE passes through a 2-flop synchronizer; the falling edge of the synchronized E defines one bus transaction.
REQ-017 While synchronized E is high, RW, DI, CS1, CS2 and DATA_IN are captured every cycle; the transaction executes in the cycle after the falling edge, using the last captured values.
REQ-018 A transaction with both CS low is ignored.
REQ-019 Instruction writes (DI=0, RW=0) go to each selected chip: 0x3F display on; 0x3E display off; 01yyyyyy set Y = y; 10111ppp set page = p; 11llllll start line = l; all other codes ignored.
REQ-020 Data write (DI=1, RW=0): RAM[chip][page][Y] <= data for each selected chip; Y increments modulo 64 (63 -> 0); page unchanged; WR_STROBE pulses once, even when both chips are selected.
REQ-021 Status read (DI=0, RW=1): LCD_DATA_OUT = {busy=0, 0, off=~DISP_ON[chip], reset=~LCD_RST_sync, 4'b0000}.
REQ-022 Data read (DI=1, RW=1): LCD_DATA_OUT returns the chip output latch (dummy-read semantics); at the falling edge, latch <= RAM[chip][page][Y] and Y increments modulo 64.
REQ-023 Reads with both CS high are serviced by chip 0 only; chip 1 state is unchanged.
REQ-024 LCD_DATA_OE = synchronized E & RW & (CS1 | CS2); LCD_DATA_OUT = 0x00 whenever OE is low.
REQ-025 RD_DATA is registered: valid 1 cycle after the address is applied. A same-cycle write to that address returns the old data.
REQ-026 LCD_RST is synchronized (2 flops). While it is low, both chips hold display off, start line 0, page 0 and Y 0, and bus transactions are ignored. RAM is preserved.
REQ-027 A falling edge of E that coincides with LCD_RST low is dropped; it is not queued.

Reset
REQ-028 RESET low: DISP_ON = 2'b00; START_LINE0/1 = 0; page and Y = 0; output latches = 0x00; LCD_DATA_OUT = 0x00; LCD_DATA_OE = 0; WR_STROBE = 0; RD_DATA = 0x00; synchronizers cleared.
REQ-029 RESET does not initialise display RAM; its content is undefined until written.
REQ-030 RESET asserted mid-transaction aborts the transaction; no RAM write occurs after RESET is asserted.

Structure
REQ-031 A shared package holds the opcode masks and values (ON, OFF, SET_Y, SET_PAGE, START_LINE), the status-bit positions, and the geometry constants (2 chips, 8 pages, 64 columns).
REQ-032 Display RAM is one sub-module, glcd_dpram: 1024x8, one write port plus two synchronous read ports (bus read and inspection read).

Verification
REQ-033 Write 0x3F, 0xC5, 0x40, 0xBE to both chips -> DISP_ON = 11, START_LINE0/1 = 5, page = 6, Y = 0.
REQ-034 Page 6 with CS1 only: write 64 data bytes 0x00..0x3F -> chip 0 RAM[6][n] = n; Y wraps to 0; chip 1 unchanged; exactly 64 WR_STROBE pulses.
REQ-035 Set Y = 63, write 0xAA then 0x55 -> RAM[63] = 0xAA, RAM[0] = 0x55.
REQ-036 Data read at Y = 2 after RAM[2] = 0x11 and RAM[3] = 0x22: first read returns the stale latch, second read returns 0x11, third returns 0x22; OE high only during E high.
REQ-037 Status read after 0x3E with LCD_RST high -> 0x20; with LCD_RST held low -> 0x30 and writes are ignored.
REQ-038 Assert RESET during an E-high write to RAM[0][0] = 0x77 -> RAM[0][0] is not written; all outputs reach their REQ-028 values.
